oam_dma_arbiter: RTL and testbench
==================================

// Module: oam_dma_arbiter
// PURPOSE
//  Shares the system bus between Cpu6502 and the NES sprite (OAM) DMA engine.
//  A CPU write to DMA_REG_ADDR latches a source page. The block then stalls the CPU via
//  clock-enable and copies TRANSFER_LEN bytes from {page,idx} to OAM_DATA_ADDR.
//  When idle, CPU bus signals pass through unchanged.
// PARAMETERS
//  DMA_REG_ADDR   16'h4014  CPU write address that triggers DMA
//  OAM_DATA_ADDR  16'h2004  destination address for every DMA write
//  TRANSFER_LEN   256       bytes per transfer; must be 1..256
// PORTS
//  i_clk          in   1   system clock; single clock domain
//  i_reset_n      in   1   asynchronous, active-low reset
//  i_cpu_rw       in   1   CPU read/write (1=READ, 0=WRITE)
//  i_cpu_address  in   16  CPU address
//  i_cpu_data     in   8   CPU write data
//  o_cpu_data     out  8   read data to CPU; always equals i_data
//  o_cpu_ce       out  1   CPU clock enable; 0 = CPU frozen this cycle
//  o_rw           out  1   bus read/write
//  o_address      out  16  bus address
//  o_data         out  8   bus write data
//  i_data         in   8   bus read data
//  o_busy         out  1   1 while the DMA owns the bus
// BEHAVIOUR
//  Reset: state=IDLE, page=0, idx=0, latch=0, parity=0. Hence o_cpu_ce=1, o_busy=0 and
//   bus outputs are CPU pass-through. Reset mid-transfer aborts immediately; it causes
//   no partial-write side effects after release.
//  parity: a 1-bit toggle that flips every cycle from reset.
//   0 marks a "get" cycle; 1 marks a "put" cycle.
//  States:
//   IDLE: o_rw/o_address/o_data = i_cpu_*. o_cpu_ce=1.
//    Trigger: i_cpu_rw=0 && i_cpu_address==DMA_REG_ADDR. On trigger, page<=i_cpu_data and
//    next state is HALT. The triggering CPU write completes normally on the bus.
//   HALT (1 cycle): o_cpu_ce=0, o_rw=1, o_address=i_cpu_address (dummy read).
//    Next state is ALIGN if parity of the next cycle is 1, else READ.
//   ALIGN (1 cycle): same outputs as HALT. Next state is READ.
//   READ: o_rw=1, o_address={page,idx}. latch<=i_data at the end of the cycle.
//    Next state is WRITE.
//   WRITE: o_rw=0, o_address=OAM_DATA_ADDR, o_data=latch.
//    If idx==TRANSFER_LEN-1: idx<=0 and next state is IDLE. Otherwise idx<=idx+1 and
//    next state is READ.
//  o_cpu_ce=0 and o_busy=1 in HALT, ALIGN, READ and WRITE.
//   o_cpu_ce returns to 1 in the cycle after the last WRITE.
//  Latency: trigger write in cycle T; first READ at T+2 (no ALIGN) or T+3 (ALIGN).
//   CPU stalled 513 cycles (no ALIGN) or 514 cycles (ALIGN) at TRANSFER_LEN=256.
//  idx is 8 bits. Source addresses never cross the page; {page,idx} never carries into
//   page. page=8'hFF is legal and reads FF00..FFFF.
//  A trigger cannot occur while busy because the CPU is frozen. Any DMA_REG_ADDR match
//   while busy is ignored.
//  CPU reads of DMA_REG_ADDR are plain pass-through reads with no trigger.
// CONFIGURATION
//  OAM_DMA_ALIGN_EN defined: the parity-driven ALIGN state is included, as above.
//  OAM_DMA_ALIGN_EN undefined: no ALIGN state. HALT always goes to READ, giving a fixed
//   513-cycle stall; the parity register is still present but unused.
// STRUCTURE
//  Package oam_dma_pkg:
//   - state enum: IDLE, HALT, ALIGN, READ, WRITE
//   - default address constants 16'h4014 and 16'h2004
//  No sub-module: the FSM, idx counter, parity toggle, data latch and output mux stay in
//   one module.
//  Output mux is combinational from registered state. All state is reset asynchronously.
// TESTING
//  1. Write 8'h02 to 16'h4014 at even parity (no ALIGN) -> READ 0200 at T+2, 256
//     READ/WRITE pairs, o_cpu_ce low exactly 513 cycles.
//  2. Same trigger at opposite parity, ALIGN enabled -> one ALIGN cycle, stall 514
//     cycles. With ALIGN disabled -> stall 513 cycles.
//  3. Memory 0300..03FF preloaded with i^8'h5A, page 8'h03 -> 256 writes to 2004 carry
//     5A,5B,58,... in order; no write goes to any other address.
//  4. Page 8'hFF -> last READ address FFFF, next WRITE 2004; no access to 0000.
//  5. Assert i_reset_n=0 at idx=8'h40 during WRITE -> same cycle: o_cpu_ce=1, o_busy=0,
//     pass-through. After release, a new 4014 write restarts at idx 0.
//  6. CPU read of 4014 and CPU write to 4015 -> no stall, o_busy stays 0, bus
//     pass-through.

Source files
------------

// File: rtl/oam_dma_pkg.sv
// State encoding and default bus addresses for the OAM DMA arbiter.
package oam_dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } dma_state_t;

  localparam logic [15:0] DMA_REG_ADDR_DEF  = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR_DEF = 16'h2004;

  function automatic logic [15:0] src_addr(input logic [7:0] page, input logic [7:0] idx);
    return {page, idx};
  endfunction

endpackage

// File: rtl/oam_dma_arbiter.sv
// Bus arbiter: a CPU write to DMA_REG_ADDR stalls the CPU (o_cpu_ce=0) while TRANSFER_LEN bytes copy {page,idx} -> OAM_DATA_ADDR.
// First source read lands 2 cycles after the trigger, or 3 when OAM_DMA_ALIGN_EN inserts the parity ALIGN cycle.
module oam_dma_arbiter
  import oam_dma_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = DMA_REG_ADDR_DEF,
  parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA_ADDR_DEF,
  parameter int          TRANSFER_LEN  = 256
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_cpu_rw,
  input  logic [15:0] i_cpu_address,
  input  logic [7:0]  i_cpu_data,
  output logic [7:0]  o_cpu_data,
  output logic        o_cpu_ce,
  output logic        o_rw,
  output logic [15:0] o_address,
  output logic [7:0]  o_data,
  input  logic [7:0]  i_data,
  output logic        o_busy
);

  localparam logic [7:0] LAST_IDX = 8'(TRANSFER_LEN - 1);

  dma_state_t state;
  logic [7:0] page;
  logic [7:0] idx;
  logic [7:0] latch;
  logic       parity;
  logic       trigger;

  assign trigger    = !i_cpu_rw && (i_cpu_address == DMA_REG_ADDR);
  assign o_cpu_data = i_data;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state  <= IDLE;
      page   <= 8'h00;
      idx    <= 8'h00;
      latch  <= 8'h00;
      parity <= 1'b0;
    end else begin
      parity <= ~parity;
      case (state)
        IDLE: begin
          if (trigger) begin
            page  <= i_cpu_data;
            state <= HALT;
          end
        end
        HALT: begin
`ifdef OAM_DMA_ALIGN_EN
          // next cycle's parity is ~parity; reads must fall on "get" (parity 0) cycles
          state <= parity ? READ : ALIGN;
`else
          state <= READ;
`endif
        end
        ALIGN: state <= READ;
        READ: begin
          latch <= i_data;
          state <= WRITE;
        end
        WRITE: begin
          if (idx == LAST_IDX) begin
            idx   <= 8'h00;
            state <= IDLE;
          end else begin
            idx   <= idx + 8'd1;
            state <= READ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef OAM_DMA_ALIGN_EN
  logic unused_parity;
  assign unused_parity = parity;
`endif

  // Output mux decodes straight from state so an async reset returns the bus in the same cycle.
  always_comb begin
    o_cpu_ce  = 1'b1;
    o_busy    = 1'b0;
    o_rw      = i_cpu_rw;
    o_address = i_cpu_address;
    o_data    = i_cpu_data;
    case (state)
      HALT, ALIGN: begin
        o_cpu_ce = 1'b0;
        o_busy   = 1'b1;
        o_rw     = 1'b1;
      end
      READ: begin
        o_cpu_ce  = 1'b0;
        o_busy    = 1'b1;
        o_rw      = 1'b1;
        o_address = src_addr(page, idx);
      end
      WRITE: begin
        o_cpu_ce  = 1'b0;
        o_busy    = 1'b1;
        o_rw      = 1'b0;
        o_address = OAM_DATA_ADDR;
        o_data    = latch;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Randomized bench for oam_dma_arbiter against a formula-based transfer model; honours OAM_DMA_ALIGN_EN.
module tb_oam_dma_arbiter;

`ifdef OAM_DMA_ALIGN_EN
  localparam int ALIGN_EN = 1;
`else
  localparam int ALIGN_EN = 0;
`endif
  localparam int LEN = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_rw;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ce;
  logic        bus_rw;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        busy;

  logic [7:0] mem [0:65535];
  int total = 0;
  int bad   = 0;
  int cnt   = 0;

  assign bus_rdata = mem[bus_addr];

  oam_dma_arbiter dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_cpu_rw     (cpu_rw),
    .i_cpu_address(cpu_addr),
    .i_cpu_data   (cpu_wdata),
    .o_cpu_data   (cpu_rdata),
    .o_cpu_ce     (cpu_ce),
    .o_rw         (bus_rw),
    .o_address    (bus_addr),
    .o_data       (bus_wdata),
    .i_data       (bus_rdata),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  // vector layout: [34] ce, [33] busy, [32] rw, [31:16] addr, [15:8] bus wdata, [7:0] cpu rdata
  task automatic chk(input string tag, input logic [34:0] got, input logic [34:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cnt++;
    #1;
  endtask

  function automatic logic [34:0] obs_vec(input logic mask_data);
    return {cpu_ce, busy, bus_rw, bus_addr, (mask_data ? 8'h00 : bus_wdata), cpu_rdata};
  endfunction

  function automatic logic [34:0] pass_vec();
    return {1'b1, 1'b0, cpu_rw, cpu_addr, cpu_wdata, mem[cpu_addr]};
  endfunction

  // k counts cycles after the trigger: 1+align halt cycles, then alternating read/write per byte
  function automatic logic [34:0] dma_vec(input logic [7:0] page, input int k, input int align);
    int j;
    logic [7:0]  idx;
    logic [15:0] a;
    j = k - 2 - align;
    if (j < 0) return {1'b0, 1'b1, 1'b1, cpu_addr, 8'h00, mem[cpu_addr]};
    idx = 8'(j / 2);
    a   = {page, idx};
    if (j % 2 == 0) return {1'b0, 1'b1, 1'b1, a, 8'h00, mem[a]};
    return {1'b0, 1'b1, 1'b0, 16'h2004, mem[a], mem[16'h2004]};
  endfunction

  task automatic idle_cycle(input logic rw, input logic [15:0] a, input logic [7:0] d, input string tag);
    cpu_rw = rw;
    cpu_addr = a;
    cpu_wdata = d;
    @(negedge clk);
    chk(tag, obs_vec(1'b0), pass_vec());
    tick();
  endtask

  task automatic idle_rand();
    logic rw;
    logic [15:0] a;
    rw = 1'($urandom);
    a  = 16'($urandom);
    if (!rw && a == 16'h4014) a = 16'h4015;
    idle_cycle(rw, a, 8'($urandom), "idle");
  endtask

  task automatic run_dma(input logic [7:0] page, input int par, input int abort_idx);
    int align;
    int lows;
    int stall;
    bit aborted;
    logic [34:0] e;
    if (cnt % 2 != par) idle_rand();
    align = (ALIGN_EN != 0 && par == 1) ? 1 : 0;
    stall = 2 * LEN + 1 + align;
    cpu_rw = 1'b0;
    cpu_addr = 16'h4014;
    cpu_wdata = page;
    @(negedge clk);
    chk("trigger", obs_vec(1'b0), pass_vec());
    tick();
    lows = 0;
    aborted = 0;
    for (int k = 1; k <= stall && !aborted; k++) begin
      cpu_rw = 1'($urandom);
      cpu_addr = ($urandom_range(0, 3) == 0) ? 16'h4014 : 16'($urandom);
      cpu_wdata = 8'($urandom);
      @(negedge clk);
      if (abort_idx >= 0 && k == 2 * abort_idx + 3 + align) begin
        rst_n = 1'b0;
        #1;
        chk("abort", obs_vec(1'b0), pass_vec());
        aborted = 1;
      end else begin
        e = dma_vec(page, k, align);
        chk($sformatf("dma pg%02h k%0d", page, k), obs_vec(e[32]), e);
        if (!cpu_ce) lows++;
        tick();
      end
    end
    if (aborted) begin
      @(negedge clk);
      chk("in_reset", obs_vec(1'b0), pass_vec());
      cpu_rw = 1'b1;
      rst_n = 1'b1;
      cnt = 0;
      tick();
      idle_cycle(1'b1, 16'h2004, 8'h00, "post_abort");
    end else begin
      chk($sformatf("stall_len pg%02h", page), 35'(lows), 35'(stall));
      idle_cycle(1'b1, 16'($urandom), 8'($urandom), "resume");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    cpu_rw = 1'b1;
    cpu_addr = 16'h0000;
    cpu_wdata = 8'h00;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'(16'h0300 + i)] = 8'(i) ^ 8'h5A;

    repeat (2) @(negedge clk);
    cpu_rw = 1'b0;
    cpu_addr = 16'h4014;
    cpu_wdata = 8'h77;
    #1;
    chk("reset_state", obs_vec(1'b0), pass_vec());
    @(negedge clk);
    cpu_rw = 1'b1;
    rst_n = 1'b1;
    cnt = 0;
    tick();

    idle_cycle(1'b1, 16'h4014, 8'h02, "read_4014");
    idle_cycle(1'b0, 16'h4015, 8'h02, "write_4015");
    idle_cycle(1'b1, 16'h4014, 8'h55, "after_4015");
    repeat (20) idle_rand();

    run_dma(8'h02, 0, -1);
    run_dma(8'h02, 1, -1);
    run_dma(8'h03, int'($urandom_range(0, 1)), -1);
    run_dma(8'hFF, 0, -1);
    run_dma(8'($urandom), 1, 8'h40);
    run_dma(8'h03, 0, -1);
    repeat (5) idle_rand();
    run_dma(8'($urandom), int'($urandom_range(0, 1)), -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
